// File: rtl/ft232r_tx_fc.sv
// FT232R transmit path: req/ack byte intake, hold + shift double buffer, 8N1 serializer gated by rts_n.
// Define FT232R_TX_FC_TIMEOUT_EN to add a stall timeout that forces the frame out and sets sticky fc_timeout.
module ft232r_tx_fc #(
   parameter int P_CLK_FREQ_HZ    = 125_000_000,
   parameter int P_BAUD_RATE      = 2_500_000,
   parameter int P_FC_TIMEOUT_CYC = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   output logic       rxd,
   input  logic       rts_n,
   input  logic       rsp_req,
   input  logic [7:0] rsp_data,
   output logic       rsp_ack,
   output logic       busy,
   output logic       fc_stall,
   output logic       fc_timeout
);
   localparam int DIV = P_CLK_FREQ_HZ / P_BAUD_RATE;
   localparam int BW  = $clog2(DIV);
   typedef logic [BW-1:0] baud_t;
   localparam baud_t BAUD_LAST = baud_t'(DIV - 1);

   if (DIV < 4 || P_FC_TIMEOUT_CYC < 1) begin : g_bad_param
      $error("ft232r_tx_fc: clock/baud ratio must be >= 4 and timeout >= 1");
   end

   typedef enum logic {H_IDLE, H_ACK} hs_t;
   typedef enum logic [2:0] {S_IDLE, S_WAIT_FC, S_START, S_DATA, S_STOP} tx_t;

   hs_t        hs_q, hs_d;
   tx_t        tx_q, tx_d;
   logic       rts_meta_q, rts_sync_q;
   logic       ack_q, ack_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_valid_q, hold_valid_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_q, bit_d;
   baud_t      baud_q, baud_d;
   logic       rxd_q, rxd_d;
   logic       load, drain, fc_fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         rts_meta_q   <= 1'b1;
         rts_sync_q   <= 1'b1;
         hs_q         <= H_IDLE;
         ack_q        <= 1'b0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         tx_q         <= S_IDLE;
         shift_q      <= '0;
         bit_q        <= '0;
         baud_q       <= '0;
         rxd_q        <= 1'b1;
      end else begin
         rts_meta_q   <= rts_n;
         rts_sync_q   <= rts_meta_q;
         hs_q         <= hs_d;
         ack_q        <= ack_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         tx_q         <= tx_d;
         shift_q      <= shift_d;
         bit_q        <= bit_d;
         baud_q       <= baud_d;
         rxd_q        <= rxd_d;
      end
   end

   always_comb begin
      hs_d    = hs_q;
      ack_d   = ack_q;
      hold_d  = hold_q;
      tx_d    = tx_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      baud_d  = baud_q;
      load    = 1'b0;
      drain   = 1'b0;

      // Load looks at the registered hold_valid, so a same-cycle drain defers the load by one cycle.
      case (hs_q)
         H_IDLE: if (rsp_req && !hold_valid_q) begin
            hold_d = rsp_data;
            load   = 1'b1;
            ack_d  = 1'b1;
            hs_d   = H_ACK;
         end
         H_ACK: if (!rsp_req) begin
            ack_d = 1'b0;
            hs_d  = H_IDLE;
         end
         default: hs_d = H_IDLE;
      endcase

      case (tx_q)
         S_IDLE: if (hold_valid_q) begin
            shift_d = hold_q;
            drain   = 1'b1;
            tx_d    = S_WAIT_FC;
         end
         S_WAIT_FC: if (!rts_sync_q || fc_fire) begin
            tx_d   = S_START;
            baud_d = '0;
         end
         S_START: begin
            baud_d = baud_q + baud_t'(1);
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               bit_d  = '0;
               tx_d   = S_DATA;
            end
         end
         S_DATA: begin
            baud_d = baud_q + baud_t'(1);
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d = S_STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
         S_STOP: begin
            baud_d = baud_q + baud_t'(1);
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               tx_d   = S_IDLE;
            end
         end
         default: tx_d = S_IDLE;
      endcase

      hold_valid_d = hold_valid_q;
      if (load)       hold_valid_d = 1'b1;
      else if (drain) hold_valid_d = 1'b0;

      // rxd is registered from the next state so line transitions line up with state changes.
      case (tx_d)
         S_START: rxd_d = 1'b0;
         S_DATA:  rxd_d = shift_d[0];
         default: rxd_d = 1'b1;
      endcase
   end

   assign rxd      = rxd_q;
   assign rsp_ack  = ack_q;
   assign busy     = hold_valid_q | (tx_q != S_IDLE);
   assign fc_stall = (tx_q == S_WAIT_FC) && rts_sync_q;

`ifdef FT232R_TX_FC_TIMEOUT_EN
   localparam int TW = $clog2(P_FC_TIMEOUT_CYC + 1);
   typedef logic [TW-1:0] to_t;
   localparam to_t TO_LAST = to_t'(P_FC_TIMEOUT_CYC - 1);

   to_t  to_cnt_q, to_cnt_d;
   logic to_flag_q, to_flag_d;

   assign fc_fire   = fc_stall && (to_cnt_q == TO_LAST);
   assign to_cnt_d  = (fc_stall && !fc_fire) ? to_cnt_q + to_t'(1) : '0;
   assign to_flag_d = to_flag_q | fc_fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_q  <= '0;
         to_flag_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         to_flag_q <= to_flag_d;
      end
   end

   assign fc_timeout = to_flag_q;
`else
   assign fc_fire    = 1'b0;
   assign fc_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ft232r_tx_fc.sv
// Bench for ft232r_tx_fc: line monitor decodes every 8N1 frame against the queue of accepted bytes.
// Directed flow-control/back-to-back/reset cases followed by randomized traffic with random rts_n.
module tb_ft232r_tx_fc;
   localparam int DIV = 50;
   localparam int TO  = 100;
`ifdef FT232R_TX_FC_TIMEOUT_EN
   localparam int STALL_N = 60;
`else
   localparam int STALL_N = 2000;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd;
   logic       rts_n = 1'b0;
   logic       rsp_req = 1'b0;
   logic [7:0] rsp_data = 8'h00;
   logic       rsp_ack, busy, fc_stall, fc_timeout;

   ft232r_tx_fc #(
      .P_CLK_FREQ_HZ(125_000_000),
      .P_BAUD_RATE(2_500_000),
      .P_FC_TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .rts_n(rts_n),
      .rsp_req(rsp_req), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
      .busy(busy), .fc_stall(fc_stall), .fc_timeout(fc_timeout)
   );

   always #4 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Reference: an ideal 8N1 frame is DIV low, 8 data bits LSB first of DIV each, DIV high.
   logic [7:0] exp_q[$];
   logic       rts_seen[8];
   int         nframes = 0, in_frame = 0, fstart = 0, fpos, fdev, last_end = -100;
   int         fend[64], fgap[64];
   logic [7:0] fexp, fgot;
   logic       fbusy_last, e;

   initial forever begin
      @(negedge clk);
      rts_seen[(cyc + 1) & 7] = rts_n;
      if (rst) begin
         in_frame = 0;
      end else if (!in_frame && rxd === 1'b0) begin
         in_frame = 1;
         fstart   = cyc;
         fdev     = 0;
         fgot     = 8'h00;
         fgap[nframes & 63] = cyc - last_end - 1;
         if (!fc_timeout) chk("start_needs_rts_low", rts_seen[(cyc - 2) & 7], 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
            fexp = 8'h00;
         end else begin
            fexp = exp_q.pop_front();
         end
      end
      if (in_frame) begin
         fpos = cyc - fstart;
         if (fpos < DIV)          e = 1'b0;
         else if (fpos < 9 * DIV) e = fexp[(fpos - DIV) / DIV];
         else                     e = 1'b1;
         if (rxd !== e) fdev++;
         if (fpos >= DIV && fpos < 9 * DIV && (fpos - DIV) % DIV == DIV / 2)
            fgot[(fpos - DIV) / DIV] = rxd;
         if (fpos == 10 * DIV - 1) begin
            chk("frame_byte", fgot, fexp);
            chk("frame_shape", fdev, 0);
            fbusy_last = busy;
            fend[nframes & 63] = cyc;
            last_end = cyc;
            nframes++;
            in_frame = 0;
         end
      end
   end

   task automatic send(input logic [7:0] b, output int lat, output int ack_cyc);
      int t;
      t = 0;
      rsp_data = b;
      rsp_req  = 1'b1;
      do begin @(posedge clk); #1; t++; end while (!rsp_ack && t < 5000);
      lat = t;
      ack_cyc = cyc;
      if (!rsp_ack) chk("ack_timeout", 0, 1);
      else exp_q.push_back(b);
      rsp_req = 1'b0;
      t = 0;
      do begin @(posedge clk); #1; t++; end while (rsp_ack && t < 10);
      chk("ack_fall_lat", t, 1);
   endtask

   task automatic wait_frames(input int n, input int lim);
      int t;
      t = 0;
      while (nframes < n && t < lim) begin @(posedge clk); t++; end
      #1;
      if (nframes < n) chk("wait_frames_timeout", nframes, n);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #(8 * 90000);
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   bit tog_run;

   initial begin
      int lat, ac, lat1, lat2, lat3, ac3, n0, viol, t, tgt;

      // reset state
      idle(3);
      chk("rst_rxd", rxd, 1);
      chk("rst_ack", rsp_ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fc_stall", fc_stall, 0);
      chk("rst_fc_timeout", fc_timeout, 0);
      rst = 1'b0;
      idle(3);

      // single byte, rts low
      send(8'hA5, lat, ac);
      chk("t1_ack_lat", lat, 1);
      wait_frames(1, 1000);
      chk("t1_busy_in_stop", fbusy_last, 1);
      chk("t1_busy_after", busy, 0);

      // held off by rts_n high
      rts_n = 1'b1;
      idle(3);
      n0 = nframes;
      send(8'h3C, lat, ac);
      viol = 0;
      repeat (STALL_N) begin
         @(posedge clk); #1;
         if (!fc_stall || rxd !== 1'b1) viol++;
      end
      chk("t2_stall_viol", viol, 0);
      chk("t2_no_frame", nframes, n0);
      chk("t2_busy", busy, 1);
      rts_n = 1'b0;
      t = 0;
      do begin @(posedge clk); #1; t++; end while (rxd && t < 20);
      chk("t2_start_lat_3_4", (t >= 3 && t <= 4), 1);
      wait_frames(n0 + 1, 1000);

      // three back-to-back requests
      idle(5);
      n0 = nframes;
      send(8'h01, lat1, ac);
      send(8'h02, lat2, ac);
      send(8'h03, lat3, ac3);
      chk("t3_ack1_lat", lat1, 1);
      chk("t3_ack2_lat", lat2, 1);
      chk("t3_ack3_after_f1", ac3 - fend[n0 & 63], 3);
      wait_frames(n0 + 3, 3000);
      chk("t3_gap12", fgap[(n0 + 1) & 63], 2);
      chk("t3_gap23", fgap[(n0 + 2) & 63], 2);

      // rts_n rises mid data bit 3
      idle(5);
      n0 = nframes;
      send(8'hFF, lat, ac);
      send(8'h5A, lat, ac);
      t = 0;
      while (!in_frame && t < 100) begin @(posedge clk); #1; t++; end
      tgt = fstart + DIV + 3 * DIV + DIV / 2;
      while (cyc < tgt) begin @(posedge clk); #1; end
      rts_n = 1'b1;
      wait_frames(n0 + 1, 1000);
      idle(1);
      viol = 0;
      repeat (STALL_N) begin
         @(posedge clk); #1;
         if (!fc_stall || rxd !== 1'b1) viol++;
      end
      chk("t4_queued_waits", viol, 0);
      chk("t4_one_frame", nframes, n0 + 1);
      rts_n = 1'b0;
      wait_frames(n0 + 2, 1000);

      // randomized traffic with random flow control
      idle(5);
      n0 = nframes;
      tog_run = 1'b1;
      fork
         while (tog_run) begin
            repeat ($urandom_range(20, 300)) @(posedge clk);
            #1;
            if (tog_run) rts_n = ($urandom_range(0, 2) == 0);
         end
      join_none
      for (int i = 0; i < 10; i++) begin
         idle($urandom_range(1, 400));
         send(8'($urandom_range(0, 255)), lat, ac);
      end
      tog_run = 1'b0;
      idle(310);
      rts_n = 1'b0;
      wait_frames(n0 + 10, 20000);
      idle(3);
      chk("rnd_queue_empty", exp_q.size(), 0);
      chk("rnd_busy_end", busy, 0);

      // reset at bit 4 with a second byte held
      n0 = nframes;
      send(8'h55, lat, ac);
      send(8'h33, lat, ac);
      t = 0;
      while (!in_frame && t < 100) begin @(posedge clk); #1; t++; end
      tgt = fstart + DIV + 4 * DIV + DIV / 2;
      while (cyc < tgt) begin @(posedge clk); #1; end
      rst = 1'b1;
      idle(1);
      chk("t5_rxd", rxd, 1);
      chk("t5_busy", busy, 0);
      chk("t5_ack", rsp_ack, 0);
      rst = 1'b0;
      exp_q.delete();
      viol = 0;
      repeat (1200) begin
         @(posedge clk); #1;
         if (rxd !== 1'b1 || busy) viol++;
      end
      chk("t5_line_quiet", viol, 0);
      chk("t5_no_frames", nframes, n0);
      send(8'hC3, lat, ac);
      chk("t5_recover_ack_lat", lat, 1);
      wait_frames(n0 + 1, 1000);

`ifdef FT232R_TX_FC_TIMEOUT_EN
      // timeout override
      chk("t6_to_clear", fc_timeout, 0);
      rts_n = 1'b1;
      idle(3);
      n0 = nframes;
      send(8'h81, lat, ac);
      t = 0;
      do begin @(posedge clk); #1; t++; end while (rxd && t < 500);
      chk("t6_start_at_timeout", (t >= TO && t <= TO + 2), 1);
      chk("t6_flag_set", fc_timeout, 1);
      wait_frames(n0 + 1, 1000);
      idle(20);
      chk("t6_flag_sticky", fc_timeout, 1);
`else
      chk("fc_timeout_tied_low", fc_timeout, 0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/ft232r_tx_fc.md
Name: ft232r_tx_fc

Overview:
FPGA-to-FT232R transmit path with hardware flow control. It accepts bytes from FPGA logic over a 4-phase req/ack handshake and buffers them in a holding register plus a shift register. It serializes each byte as 8N1 on rxd, starting a frame only while the FT232R asserts rts_n low. It sits beside the existing receive-side FT232R adapter and replaces the unthrottled rsp path.

Parameters:
P_CLK_FREQ_HZ, 125_000_000, system clock frequency in Hz.
P_BAUD_RATE, 2_500_000, line rate in baud; DIV = P_CLK_FREQ_HZ/P_BAUD_RATE (50 at defaults), integer, must be >= 4.
P_FC_TIMEOUT_CYC, 1_000_000, cycles of continuous rts_n high stall before the flow-control override (macro build only).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
rxd  out  1  serial data to FT232R (line idles high).
rts_n  in  1  FT232R ready-to-receive, active low; asynchronous to clk.
rsp_req  in  1  logic requests a byte write; rsp_data stable while high.
rsp_data  in  8  byte to transmit.
rsp_ack  out  1  byte accepted.
busy  out  1  high while the holding register is valid or a frame is in progress.
fc_stall  out  1  high while in WAIT_FC with rts_sync high.
fc_timeout  out  1  sticky override flag; tied 0 without the macro.

Behaviour:
- Reset values: rxd=1, rsp_ack=0, busy=0, fc_stall=0, fc_timeout=0, hold_valid=0, tx FSM=IDLE, rts sync flops=1 (not ready).
- rts_n passes through a 2-flop synchronizer to produce rts_sync. No other input is synchronized.
- Handshake FSM:
  - H_IDLE: if rsp_req=1 and hold_valid=0, latch rsp_data into the hold register, set hold_valid, set rsp_ack=1 on the next edge, go to H_ACK.
  - H_ACK: hold rsp_ack=1 until rsp_req=0, then rsp_ack=0 on the next edge and go to H_IDLE.
  - A new byte is never latched while in H_ACK.
- Tx FSM (bit counter 0..7, baud counter 0..DIV-1):
  - IDLE: if hold_valid, copy hold into the shift register, clear hold_valid, go to WAIT_FC.
  - WAIT_FC: if rts_sync=0, go to START; rxd=0 from the next edge.
  - START: rxd=0 for exactly DIV cycles, then DATA.
  - DATA: 8 bits LSB first, each exactly DIV cycles.
  - STOP: rxd=1 for DIV cycles, then IDLE.
- Flow control is evaluated only in WAIT_FC. A rts_n rise mid-frame does not truncate the frame; the current byte always completes.
- Simultaneous hold drain (IDLE) and hold load (H_IDLE):
  - The load sees hold_valid as of the current cycle, so no byte is lost or duplicated.
  - A load is accepted the cycle after a drain.
- Double buffering:
  - One byte can be acknowledged while the previous byte is still shifting.
  - A third request waits (ack held low) until the hold register drains.
- Back-to-back frames: 2-cycle idle gap (IDLE + WAIT_FC) between the end of the stop bit and the next start bit when rts_sync=0.
- busy = hold_valid | (tx FSM != IDLE).
- Reset mid-frame: rxd returns high on the next edge and the hold byte is discarded. If rsp_req is still high after reset, it is handled as a fresh request.

Optional Feature:
Macro FT232R_TX_FC_TIMEOUT_EN.
- Defined:
  - A counter runs while in WAIT_FC with rts_sync=1.
  - On reaching P_FC_TIMEOUT_CYC, the FSM goes to START regardless of rts_n and sets fc_timeout=1.
  - fc_timeout is sticky until rst.
  - The counter clears on leaving WAIT_FC.
- Undefined: no counter; WAIT_FC blocks indefinitely; fc_timeout is constant 0.

Test Plan:
1. rts_n=0, send 0xA5 via req/ack -> rsp_ack high 1 cycle after req; rxd start bit 50 cycles, then bits 1,0,1,0,0,1,0,1, stop; frame 500 cycles; busy falls after stop.
2. rts_n=1, send 0x3C; hold 2000 cycles, then rts_n=0 -> fc_stall=1 and rxd=1 throughout the hold; start bit begins 3-4 cycles after rts_n falls (2-flop sync + state change); byte correct.
3. Three back-to-back requests 0x01,0x02,0x03 with rts_n=0 -> first two acked immediately, third acked only after frame 1 ends; frames separated by 2-cycle gaps; bytes in order.
4. rts_n raised at mid-data-bit 3 of 0xFF -> frame completes intact; the next queued byte waits in WAIT_FC until rts_n=0.
5. rst pulsed at bit 4 of 0x55 with a second byte held -> rxd=1 next edge, busy=0, rsp_ack=0; the second byte is never transmitted.
6. With FT232R_TX_FC_TIMEOUT_EN and P_FC_TIMEOUT_CYC=100, rts_n=1, send 0x81 -> start bit at timeout; fc_timeout=1 and stays 1 after frame end; without the macro, rxd stays 1 indefinitely.
